// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: decode issue/hazard query, EXU/LSU writeback requests
// and the register-file write port.
interface regfile_wb_arbiter_if #(
   parameter int unsigned XLEN = 64
);
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            issue_ready;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            exu_valid;
   logic [4:0]      exu_rd;
   logic [XLEN-1:0] exu_wdata;
   logic            exu_ready;
   logic            lsu_valid;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_wdata;
   logic            lsu_ready;
   logic            reg_wen;
   logic [4:0]      rd;
   logic [XLEN-1:0] rd_wdata;

   // Arbiter side
   modport slave (
      input  issue_valid, issue_rd, rs1, rs2,
      input  exu_valid, exu_rd, exu_wdata,
      input  lsu_valid, lsu_rd, lsu_wdata,
      output issue_ready, rs1_busy, rs2_busy,
      output exu_ready, lsu_ready,
      output reg_wen, rd, rd_wdata
   );

   // Decode / requester / register-file side
   modport master (
      output issue_valid, issue_rd, rs1, rs2,
      output exu_valid, exu_rd, exu_wdata,
      output lsu_valid, lsu_rd, lsu_wdata,
      input  issue_ready, rs1_busy, rs2_busy,
      input  exu_ready, lsu_ready,
      input  reg_wen, rd, rd_wdata
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin EXU/LSU arbiter for the single register-file write port, plus a
// busy-bit scoreboard of pending destination registers for RAW stall detection.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NREG = 32
) (
   input logic                  clock,
   input logic                  reset,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int unsigned RW = $clog2(NREG);

   typedef enum logic {
      GNT_EXU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

   grant_e          r_last_grant;
   logic [NREG-1:0] r_busy;
   logic            r_reg_wen;
   logic [RW-1:0]   r_rd;
   logic [XLEN-1:0] r_rd_wdata;

   logic            w_exu_gnt;
   logic            w_lsu_gnt;
   logic            w_hs;
   logic [RW-1:0]   w_hs_rd;
   logic [XLEN-1:0] w_hs_data;
   logic            w_issue_ready;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;
   logic [NREG-1:0] w_busy_nxt;

   // Grant depends only on the valids and the previous winner
   always_comb begin
      w_exu_gnt = 1'b0;
      w_lsu_gnt = 1'b0;
      if (bus.exu_valid && bus.lsu_valid) begin
         if (r_last_grant == GNT_LSU) w_exu_gnt = 1'b1;
         else                         w_lsu_gnt = 1'b1;
      end else begin
         w_exu_gnt = bus.exu_valid;
         w_lsu_gnt = bus.lsu_valid;
      end
   end

   assign w_hs      = w_exu_gnt | w_lsu_gnt;
   assign w_hs_rd   = w_lsu_gnt ? RW'(bus.lsu_rd)      : RW'(bus.exu_rd);
   assign w_hs_data = w_lsu_gnt ? XLEN'(bus.lsu_wdata) : XLEN'(bus.exu_wdata);

   assign w_issue_ready = (bus.issue_rd == 5'd0) || !r_busy[RW'(bus.issue_rd)];

   assign bus.issue_ready = w_issue_ready;
   assign bus.rs1_busy    = (bus.rs1 != 5'd0) && r_busy[RW'(bus.rs1)];
   assign bus.rs2_busy    = (bus.rs2 != 5'd0) && r_busy[RW'(bus.rs2)];
   assign bus.exu_ready   = w_exu_gnt;
   assign bus.lsu_ready   = w_lsu_gnt;
   assign bus.reg_wen     = r_reg_wen;
   assign bus.rd          = 5'(r_rd);
   assign bus.rd_wdata    = r_rd_wdata;

   // Scoreboard next state: a same-cycle set overrides a clear
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (bus.issue_valid && w_issue_ready && (bus.issue_rd != 5'd0))
         w_set[RW'(bus.issue_rd)] = 1'b1;
      if (w_hs && (w_hs_rd != '0))
         w_clr[w_hs_rd] = 1'b1;
      w_busy_nxt    = (r_busy & ~w_clr) | w_set;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy       <= '0;
         r_last_grant <= GNT_LSU;
         r_reg_wen    <= 1'b0;
         r_rd         <= '0;
         r_rd_wdata   <= '0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_reg_wen <= w_hs && (w_hs_rd != '0);
         if (w_hs) begin
            r_last_grant <= w_lsu_gnt ? GNT_LSU : GNT_EXU;
            r_rd         <= w_hs_rd;
            r_rd_wdata   <= w_hs_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter with a queue-based write
// expectation and a behavioural busy/round-robin model.
module tb_regfile_wb_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   regfile_wb_arbiter_if #(.XLEN(64)) bus ();

   regfile_wb_arbiter #(.XLEN(64), .NREG(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_pass  = 0;
   int  n_total = 0;

   // reference model state
   bit  m_busy[32];
   bit  m_last_lsu;

   // stimulus state: issue, source queries, and the two requesters
   logic        iv;
   logic [4:0]  ird, r1, r2;
   logic        e_v, l_v;
   logic [4:0]  e_rd, l_rd;
   logic [63:0] e_d, l_d;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      else n_pass++;
   endtask

   function automatic bit m_is_busy(input logic [4:0] r);
      return (r != 0) && m_busy[r];
   endfunction

   task automatic drive_idle();
      iv = 0; ird = 0; r1 = 0; r2 = 0;
      e_v = 0; e_rd = 0; e_d = 0;
      l_v = 0; l_rd = 0; l_d = 0;
      bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
      bus.exu_valid = 0; bus.exu_rd = 0; bus.exu_wdata = 0;
      bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_wdata = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      exp_q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_last_lsu = 1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // One cycle: drive at negedge, check combinational outputs, advance model
   task automatic step();
      bit eg, lg, ir;
      wr_t w;
      @(negedge clock);
      bus.issue_valid = iv; bus.issue_rd = ird; bus.rs1 = r1; bus.rs2 = r2;
      bus.exu_valid = e_v; bus.exu_rd = e_rd; bus.exu_wdata = e_d;
      bus.lsu_valid = l_v; bus.lsu_rd = l_rd; bus.lsu_wdata = l_d;
      #1;
      if (e_v && l_v) begin eg = m_last_lsu; lg = !m_last_lsu; end
      else begin eg = e_v; lg = l_v; end
      ir = (ird == 0) || !m_busy[ird];
      chk("exu_ready", 64'(bus.exu_ready), 64'(eg));
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(lg));
      chk("issue_ready", 64'(bus.issue_ready), 64'(ir));
      chk("rs1_busy", 64'(bus.rs1_busy), 64'(m_is_busy(r1)));
      chk("rs2_busy", 64'(bus.rs2_busy), 64'(m_is_busy(r2)));
      w.wen = 0; w.rd = 0; w.d = 0;
      if (eg) begin w.wen = (e_rd != 0); w.rd = e_rd; w.d = e_d; end
      if (lg) begin w.wen = (l_rd != 0); w.rd = l_rd; w.d = l_d; end
      exp_q.push_back(w);
      if (eg || lg) begin
         m_busy[w.rd] = 0;
         m_last_lsu = lg;
      end
      if (iv && ir && ird != 0) m_busy[ird] = 1;
      m_busy[0] = 0;
      if (eg) e_v = 0;
      if (lg) l_v = 0;
   endtask

   // Monitor: one expected register-file write slot per stimulated cycle
   initial begin
      wr_t w;
      forever begin
         @(posedge clock);
         #1;
         if (!reset) begin
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               chk("reg_wen", 64'(bus.reg_wen), 64'(w.wen));
               if (w.wen) begin
                  chk("rd", 64'(bus.rd), 64'(w.rd));
                  chk("rd_wdata", bus.rd_wdata, w.d);
               end
            end else if (bus.reg_wen) begin
               chk("unexpected_reg_wen", 64'(bus.reg_wen), 64'd0);
            end
         end
      end
   end

   initial begin
      drive_idle();
      do_reset();

      // reset state
      @(posedge clock); #2;
      chk("rst_reg_wen", 64'(bus.reg_wen), 64'd0);
      chk("rst_rd", 64'(bus.rd), 64'd0);
      chk("rst_rd_wdata", bus.rd_wdata, 64'd0);
      for (int i = 0; i < 32; i++) begin
         bus.issue_rd = 5'(i); bus.rs1 = 5'(i);
         #1;
         chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
         chk("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
      end
      drive_idle();

      // issue rd5, EXU writes it back; rs1 observes busy set then cleared
      iv = 1; ird = 5; step();
      iv = 0; r1 = 5; e_v = 1; e_rd = 5; e_d = 64'h1234; step();
      r1 = 5; step();

      // both requesters continuously valid from reset: E, L, E, L
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (!e_v) begin e_v = 1; e_rd = 5'(1 + 2 * i); e_d = 64'hE000 + 64'(i); end
         if (!l_v) begin l_v = 1; l_rd = 5'(2 + 2 * i); l_d = 64'hA000 + 64'(i); end
         step();
      end
      while (e_v || l_v) step();

      // double issue of rd7: blocked until the writeback handshake
      iv = 1; ird = 7; r2 = 0; step();
      r2 = 0; step();
      e_v = 1; e_rd = 7; e_d = 64'h77; r2 = 7; step();
      r2 = 0; step();
      iv = 0; step();

      // LSU write to x0: handshake, no write, no busy change
      l_v = 1; l_rd = 0; l_d = 64'hFFFF; r1 = 7; step();
      r1 = 7; step();

      // reset during a staged write with busy[3] set
      do_reset();
      iv = 1; ird = 3; step();
      iv = 0; e_v = 1; e_rd = 9; e_d = 64'h99; step();
      @(posedge clock); #2;
      bus.rs1 = 3; #1;
      chk("pre_rst_reg_wen", 64'(bus.reg_wen), 64'd1);
      chk("pre_rst_busy3", 64'(bus.rs1_busy), 64'd1);
      reset = 1'b1; #1;
      chk("async_rst_reg_wen", 64'(bus.reg_wen), 64'd0);
      chk("async_rst_busy3", 64'(bus.rs1_busy), 64'd0);
      chk("async_rst_rd", 64'(bus.rd), 64'd0);
      do_reset();

      // randomized traffic with requesters holding until granted
      for (int c = 0; c < 3000; c++) begin
         iv  = ($urandom_range(0, 2) == 0);
         ird = 5'($urandom_range(0, 9));
         r1  = 5'($urandom_range(0, 9));
         r2  = 5'($urandom_range(0, 9));
         if (!e_v && $urandom_range(0, 2) != 0) begin
            e_v = 1; e_rd = 5'($urandom_range(0, 9)); e_d = {$urandom, $urandom};
         end
         if (!l_v && $urandom_range(0, 2) != 0) begin
            l_v = 1; l_rd = 5'($urandom_range(0, 9)); l_d = {$urandom, $urandom};
         end
         step();
      end
      iv = 0;
      while (e_v || l_v) step();
      step();
      @(posedge clock); #2;
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_wen/rd/rd_wdata) between two writeback requesters:
  - EXU: single-cycle ALU results.
  - LSU: loads and other long-latency results.
- Also keeps a 32-entry scoreboard of pending destination registers, so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file. Its outputs drive the register file's write port directly.

Parameters:
- XLEN, 64, data width of writeback values.
- NREG, 32, number of architectural registers. Register index width is 5.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode is issuing an instruction that will write issue_rd.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle. Combinational: issue_rd==0 or busy[issue_rd]==0.
- rs1  in  5  decode source 1 index.
- rs2  in  5  decode source 2 index.
- rs1_busy  out  1  combinational: busy[rs1], forced 0 when rs1==0.
- rs2_busy  out  1  combinational: busy[rs2], forced 0 when rs2==0.
- exu_valid  in  1  EXU writeback request.
- exu_rd  in  5  EXU destination.
- exu_wdata  in  XLEN  EXU result.
- exu_ready  out  1  EXU request granted (combinational).
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  5  LSU destination.
- lsu_wdata  in  XLEN  LSU result.
- lsu_ready  out  1  LSU request granted (combinational).
- reg_wen  out  1  register-file write enable (registered).
- rd  out  5  register-file write index (registered).
- rd_wdata  out  XLEN  register-file write data (registered).

Behaviour:
- Reset (asynchronous, immediate):
  - reg_wen=0, rd=0, rd_wdata=0.
  - All busy bits =0.
  - last_grant=LSU, so EXU wins the first conflict.
- Arbitration (combinational, round-robin):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
  - exu_ready/lsu_ready depend only on the valids and last_grant, never on the data inputs.
  - Requesters hold valid, rd and data stable until ready. Dropping valid before ready is illegal.
- last_grant update: set to the granted requester on every handshake. Unchanged when there is no grant.
- Write latency:
  - A handshake in cycle N yields reg_wen=1, rd, rd_wdata in cycle N+1. The register file commits at the end of N+1.
  - With no handshake in cycle N, reg_wen=0 in N+1. rd and rd_wdata hold their previous values.
  - A granted request with rd==0 completes its handshake but produces reg_wen=0 in N+1.
- Scoreboard:
  - set: issue_valid && issue_ready && issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - clear: a handshake in cycle N for rd!=0 clears busy[rd] at the edge ending cycle N. Readers therefore see the clear in N+1, the same cycle the value is being written. The register file read is combinational, so decode must additionally use a bypass or wait one more cycle. That choice belongs to decode; this block only reports busy.
  - Set and clear of the same index in the same cycle: set wins (busy stays 1). This cannot legally occur because issue_ready=0 for a busy rd, but it must be deterministic.
  - Clear of an index that is not busy: no effect, no error.
  - busy[0] is constant 0.
- Throughput: one writeback per cycle. With both requesters continuously valid, grants alternate EXU, LSU, EXU, …
- Reset asserted mid-operation: outputs and scoreboard are cleared immediately. An in-flight staged write is discarded (reg_wen=0 while reset is high).
- Implementation limit: at most 120 to 400 lines of RTL. No other storage beyond the 32 busy bits, last_grant and the output registers.

Test Plan:
- Reset with no requests → reg_wen=0, rd=0, rd_wdata=0, all busy=0, issue_ready=1 for any rd.
- Issue rd=5, then EXU valid with rd=5, wdata=0x1234 → exu_ready=1 the same cycle. Next cycle reg_wen=1, rd=5, rd_wdata=0x1234. rs1=5 sees rs1_busy=1 before the handshake and 0 afterwards.
- EXU and LSU valid in the same cycle from reset, then held for 4 cycles → grants E, L, E, L, and rd/rd_wdata alternate accordingly. A requester held off keeps its data until granted.
- Issue rd=7 twice back to back → second issue sees issue_ready=0 until the writeback handshake for rd=7. rs2=0 always reports rs2_busy=0.
- LSU request with rd=0, wdata=0xFFFF → lsu_ready=1, next cycle reg_wen=0, no busy change.
- Assert reset while a staged write is pending (reg_wen=1) and busy[3]=1 → reg_wen drops to 0 and busy[3]=0 immediately, without waiting for a clock edge.
